neuron_mac_accum: RTL and testbench

- Per-neuron dot-product stage that sits directly upstream of the sigmoid activation.
- Streams NUM_INPUTS (x, w) pairs in signed Q8.8 and multiply-accumulates them into a wide accumulator.
- Adds a per-neuron bias, then rounds and saturates the sum back to Q8.8.
- Presents one pre-activation value per vector on a valid/ready output that feeds the sigmoid input directly.

---
 rtl/neuron_mac_accum_if.sv | 25 ++
 rtl/neuron_mac_accum.sv | 189 ++++++++++++++++++
 tb/tb_neuron_mac_accum.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_accum_if.sv
// Valid/ready bundle between the MAC accumulator and its neighbours.
// master drives operands and out_ready; slave is the accumulator.
interface neuron_mac_accum_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] x_in;
    logic [DATA_WIDTH-1:0] w_in;
    logic [DATA_WIDTH-1:0] bias_in;
    logic [DATA_WIDTH-1:0] y_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sat_out;

    modport master (
        output in_valid, x_in, w_in, bias_in, out_ready,
        input  in_ready, y_out, out_valid, sat_out
    );

    modport slave (
        input  in_valid, x_in, w_in, bias_in, out_ready,
        output in_ready, y_out, out_valid, sat_out
    );
endinterface

// File: rtl/neuron_mac_accum.sv
// Q8.8 dot product + bias, rounded and saturated, feeding the sigmoid stage.
// Define NEURON_MAC_PIPE_EN to register the product (adds one DRAIN cycle).
module neuron_mac_accum #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int NUM_INPUTS  = 16,
    parameter int ACC_WIDTH   = 40
) (
    input logic               clk,
    input logic               reset,
    neuron_mac_accum_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int FW = FRACT_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(NUM_INPUTS + 1);

    localparam logic signed [AW-1:0] HALF =
        AW'(1) << (FW - 1);
    localparam logic signed [AW-1:0] YMAX =
        {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN =
        {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    generate
        if (NUM_INPUTS < 1 || NUM_INPUTS > 256) begin : g_bad_n
            $error("NUM_INPUTS out of range");
        end
        if (ACC_WIDTH < 2 * DATA_WIDTH + 8) begin : g_bad_acc
            $error("ACC_WIDTH too narrow");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_FINAL,
        S_OUT
    } state_t;

`ifdef NEURON_MAC_PIPE_EN
    localparam state_t S_LAST = S_DRAIN;
`else
    localparam state_t S_LAST = S_FINAL;
`endif

    state_t state;
    state_t state_nx;

    logic signed [AW-1:0] acc;
    logic [CW-1:0]        cnt;
    logic [DW-1:0]        y_q;
    logic                 sat_q;

    logic                 beat;
    logic                 last_beat;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] bias_al;
    logic signed [AW-1:0] rnd;
    logic signed [AW-1:0] r;
    logic [DW-1:0]        y_nx;
    logic                 sat_nx;

`ifdef NEURON_MAC_PIPE_EN
    logic signed [AW-1:0] prod_q;
    logic                 prod_v;
`endif

    assign prod     = $signed(bus.x_in) * $signed(bus.w_in);
    assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    assign bias_al  = {{(AW-DW-FW){bus.bias_in[DW-1]}},
                       bus.bias_in, {FW{1'b0}}};
    assign beat     = bus.in_valid & bus.in_ready;

    always_comb begin
        last_beat = 1'b0;
        if (state == S_IDLE) begin
            last_beat = (NUM_INPUTS == 1);
        end else if (state == S_ACCUM) begin
            last_beat = (cnt == CW'(NUM_INPUTS - 1));
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_ACCUM: begin
                if (beat) begin
                    state_nx = last_beat ? S_LAST : S_ACCUM;
                end
            end
            S_DRAIN: state_nx = S_FINAL;
            S_FINAL: state_nx = S_OUT;
            S_OUT: begin
                if (bus.out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            S_IDLE, S_ACCUM: bus.in_ready = ~reset;
            S_OUT:           bus.out_valid = ~reset;
            default: ;
        endcase
    end

    assign bus.y_out   = y_q;
    assign bus.sat_out = sat_q;

    // Round half toward +inf, then clip to the Q8.8 range
    always_comb begin
        rnd    = acc + HALF;
        r      = rnd >>> FW;
        y_nx   = r[DW-1:0];
        sat_nx = 1'b0;
        if (r > YMAX) begin
            y_nx   = {1'b0, {(DW-1){1'b1}}};
            sat_nx = 1'b1;
        end else if (r < YMIN) begin
            y_nx   = {1'b1, {(DW-1){1'b0}}};
            sat_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            y_q    <= '0;
            sat_q  <= 1'b0;
`ifdef NEURON_MAC_PIPE_EN
            prod_q <= '0;
            prod_v <= 1'b0;
`endif
        end else begin
`ifdef NEURON_MAC_PIPE_EN
            prod_v <= beat;
            if (beat) begin
                prod_q <= prod_ext;
            end
            if (beat && state == S_IDLE) begin
                acc <= bias_al;
                cnt <= CW'(1);
            end else begin
                if (prod_v) begin
                    acc <= acc + prod_q;
                end
                if (beat) begin
                    cnt <= cnt + 1'b1;
                end
            end
`else
            if (beat) begin
                if (state == S_IDLE) begin
                    acc <= bias_al + prod_ext;
                    cnt <= CW'(1);
                end else begin
                    acc <= acc + prod_ext;
                    cnt <= cnt + 1'b1;
                end
            end
`endif
            if (state == S_FINAL) begin
                y_q   <= y_nx;
                sat_q <= sat_nx;
            end
        end
    end
endmodule

// File: tb/tb_neuron_mac_accum.sv
// Scoreboard bench for neuron_mac_accum: directed cases plus random vectors
// checked against an integer reference of the rounded, saturated dot product.
module tb_neuron_mac_accum;
    localparam int DW = 16;
    localparam int N  = 4;
`ifdef NEURON_MAC_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [15:0] y;
        logic        sat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    neuron_mac_accum_if #(.DATA_WIDTH(DW)) bus();

    neuron_mac_accum #(
        .DATA_WIDTH(DW),
        .FRACT_WIDTH(8),
        .NUM_INPUTS(N),
        .ACC_WIDTH(40)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_beat_cyc = 0;
    int   vx[N];
    int   vw[N];
    logic rand_rdy = 1'b0;
    logic rdy_val = 1'b1;
    logic rdy_rnd = 1'b1;

    assign bus.out_ready = rand_rdy ? rdy_rnd : rdy_val;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rdy_rnd = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Reference: exact integer sum, floor((s + half) / 2^8), then clip
    function automatic exp_t ref_model(input int bias);
        longint s;
        longint r;
        exp_t   e;
        s = longint'(bias) * 256;
        for (int i = 0; i < N; i++) begin
            s += longint'(vx[i]) * longint'(vw[i]);
        end
        r = (s + 128) >>> 8;
        if (r > 32767) begin
            e = '{16'h7FFF, 1'b1};
        end else if (r < -32768) begin
            e = '{16'h8000, 1'b1};
        end else begin
            e = '{16'(r), 1'b0};
        end
        return e;
    endfunction

    function automatic int rnd_val();
        logic signed [15:0] t;
        if ($urandom_range(0, 1) == 0) begin
            t = 16'($urandom);
            return int'(t);
        end
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int x, input int w, input int b,
                             input bit gap);
        if (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.x_in     = 16'(x);
        bus.w_in     = 16'(w);
        bus.bias_in  = 16'(b);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                last_beat_cyc = cyc;
                tick();
                bus.in_valid = 1'b0;
                return;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        fail_now("beat_timeout");
    endtask

    task automatic send_vec(input int bias, input bit alt_gap,
                            input bit rnd_gap, input bit directed,
                            input exp_t e);
        bit g;
        int b;
        for (int i = 0; i < N; i++) begin
            g = (alt_gap && i != 0) ||
                (rnd_gap && $urandom_range(0, 2) == 0);
            b = (i == 0) ? bias : int'($urandom_range(0, 65535));
            send_beat(vx[i], vw[i], b, g);
        end
        sb.push_back(directed ? e : ref_model(bias));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) begin
                tick();
                return;
            end
        end
        fail_now("idle_timeout");
        tick();
    endtask

    task automatic set_vec(input int x, input int w);
        for (int i = 0; i < N; i++) begin
            vx[i] = x;
            vw[i] = w;
        end
    endtask

    // Monitor: latency, hold-while-stalled and scoreboard pop
    logic        pv = 1'b0;
    logic        phs = 1'b0;
    logic [15:0] py = '0;
    logic        ps = 1'b0;
    exp_t        me;

    always @(negedge clk) begin
        if (reset) begin
            pv  = 1'b0;
            phs = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (!pv) begin
                    check("latency", cyc - last_beat_cyc, LAT);
                end else if (!phs) begin
                    check("hold_y", bus.y_out, py);
                    check("hold_sat", bus.sat_out, ps);
                end
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        me = sb.pop_front();
                        check("y_out", bus.y_out, me.y);
                        check("sat_out", bus.sat_out, me.sat);
                    end
                end
            end
            pv  = bus.out_valid;
            phs = bus.out_valid & bus.out_ready;
            py  = bus.y_out;
            ps  = bus.sat_out;
        end
    end

    initial begin
        bit seen;
        bus.in_valid = 1'b0;
        bus.x_in     = '0;
        bus.w_in     = '0;
        bus.bias_in  = '0;

        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_y", bus.y_out, 0);
        check("rst_sat", bus.sat_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.in_ready, 1);
        tick();

        // basic dot product
        set_vec(16'h0100, 16'h0080);
        send_vec(0, 0, 0, 1, '{16'h0200, 1'b0});
        wait_idle();

        // saturation both ways
        set_vec(32767, 32767);
        send_vec(32767, 0, 0, 1, '{16'h7FFF, 1'b1});
        wait_idle();
        set_vec(-32768, 32767);
        send_vec(-32768, 0, 0, 1, '{16'h8000, 1'b1});
        wait_idle();

        // rounding
        set_vec(0, 0);
        vx[0] = 1;
        vw[0] = 128;
        send_vec(0, 0, 0, 1, '{16'h0001, 1'b0});
        wait_idle();
        vx[0] = -1;
        send_vec(0, 0, 0, 1, '{16'h0000, 1'b0});
        wait_idle();
        set_vec(0, 0);
        send_vec(-256, 0, 0, 1, '{16'hFF00, 1'b0});
        wait_idle();

        // backpressure with junk offered on the input
        rdy_val = 1'b0;
        for (int i = 0; i < N; i++) begin
            vx[i] = rnd_val();
            vw[i] = rnd_val();
        end
        send_vec(rnd_val(), 0, 0, 0, '0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        if (!seen) fail_now("bp_no_output");
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.x_in     = 16'($urandom);
            bus.w_in     = 16'($urandom);
            bus.bias_in  = 16'($urandom);
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            tick();
        end
        rdy_val = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < N; i++) begin
            vx[i] = rnd_val();
            vw[i] = rnd_val();
        end
        send_vec(rnd_val(), 0, 0, 0, '0);
        wait_idle();

        // bubbles on alternate cycles
        set_vec(16'h0100, 16'h0080);
        send_vec(0, 1, 0, 1, '{16'h0200, 1'b0});
        wait_idle();

        // reset mid-vector
        send_beat(16'h0100, 16'h0080, 16'h1234, 0);
        send_beat(16'h0100, 16'h0080, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_quiet", bus.out_valid, 0);
        end
        tick();
        send_vec(0, 0, 0, 1, '{16'h0200, 1'b0});
        wait_idle();

        // random vectors, random gaps and random out_ready
        rand_rdy = 1'b1;
        for (int v = 0; v < 40; v++) begin
            for (int i = 0; i < N; i++) begin
                vx[i] = rnd_val();
                vw[i] = rnd_val();
            end
            send_vec(rnd_val(), 0, 1, 0, '0);
        end
        wait_idle();
        rand_rdy = 1'b0;

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
